lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between the execute stage and the data-memory port.
//  Takes one request at a time over valid/ready and checks op and alignment.
//  Issues a word-aligned access with byte-lane write data and mask, waits a variable number of cycles, then returns lane-extracted, extended load data.
//  Memory side: word-aligned address, 8-bit byte mask (upper nibble always 0), little-endian.
// PARAMETERS
//  TIMEOUT  255  max WAIT cycles before an error response; 0 = wait forever
//  CNT_W    8    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk         in   1   single clock, all state on posedge
//  rst         in   1   asynchronous, active-low reset
//  req_valid   in   1   core request valid
//  req_ready   out  1   high only in IDLE
//  req_wr      in   1   1 = store, 0 = load
//  req_op      in   3   000 b, 001 h, 010 w, 100 bu, 101 hu (load extension per op)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, LSBs used for b/h
//  resp_valid  out  1   response valid, held until resp_ready
//  resp_ready  in   1   core accepts response
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   illegal op, misaligned (trap build) or timeout
//  mem_valid   out  1   memory request, held until mem_ready
//  mem_ready   in   1   memory accepted request
//  mem_wr      out  1   registered req_wr
//  mem_addr    out  32  req_addr & ~3
//  mem_wdata   out  32  store data shifted to byte lane (offset*8)
//  mem_wmask   out  8   b: 1<<off, h: 3<<off, w: 4'b1111; 0 on loads
//  mem_rvalid  in   1   read data / write completion, sampled only in WAIT
//  mem_rdata   in   32  aligned word
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE.
//   Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
//   Counter cleared.
//  States: IDLE, REQ, WAIT, RESP.
//  IDLE: req_valid&req_ready latches all req_* fields.
//   Legal, aligned request -> REQ. Illegal or faulting request -> RESP with err=1, no memory access.
//  Illegal op: 011, 110, 111, or req_wr with 100/101.
//  REQ: mem_valid=1 and mem_* stable until mem_ready; -> WAIT on mem_ready. No timeout in REQ.
//  WAIT: counter counts cycles in WAIT. mem_rvalid -> RESP with err=0.
//   Loads capture the extended result from mem_rdata: b/bu byte at off, h/hu halfword at off, w whole word.
//   Sign- or zero-extend per op. Stores return rdata=0.
//   If TIMEOUT!=0 and counter==TIMEOUT-1 without mem_rvalid -> RESP, err=1, rdata=0.
//   mem_rvalid on the same cycle as timeout: data wins, err=0.
//  RESP: resp_valid=1, data stable until resp_ready; -> IDLE on the same edge.
//   mem_rvalid outside WAIT is ignored, including late data after a timeout.
//  Latency: accept edge N; mem_valid during N+1. mem_ready at N+1 and mem_rvalid at N+2 give resp_valid at N+3. Error-path resp_valid at N+1.
//  Throughput: one request in flight; next accept is earliest the cycle after resp handshake.
//  Reset mid-operation aborts the access: all outputs return to reset values, nothing is replayed.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//   - h/hu with off=3, or w with off!=0: err response, no memory access.
//  LSU_MISALIGN_TRAP_EN undefined: never error on alignment; offset is truncated to natural alignment.
//   - h/hu: off 3 -> 2.
//   - w: off -> 0.
//   - Mask and lanes follow the truncated offset.
// TESTING
//  1 lb: addr 0x8000_0003, mem_rdata 0x80FF_1234, mem_rvalid at cycle 2 of WAIT -> mem_addr 0x8000_0000, resp_rdata 0xFFFF_FF80, err=0.
//  2 sh: addr 0x102, wdata 0xABCD_5678 -> mem_wdata 0x5678_0000, mem_wmask 8'h0C, resp_rdata 0. Repeat with lhu, mem_rdata 0x9ABC_0000 -> resp 0x0000_9ABC.
//  3 op 011 or sb with op 100 -> resp_valid the cycle after accept, err=1, mem_valid never asserted.
//  4 lw at addr 0x206: trap build -> err=1, no mem access. Non-trap build -> mem_addr 0x204, resp = mem_rdata.
//  5 TIMEOUT=4, mem_rvalid withheld -> err=1 after 4 WAIT cycles. Later mem_rvalid pulse in IDLE -> no response.
//  6 Backpressure: mem_ready low 3 cycles, resp_ready low 2 cycles -> mem_*/resp_* stable, req_ready=0 throughout. rst low in WAIT -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and the data-memory port.
// Accepts one request at a time, checks op and alignment, issues a word-aligned
// access with byte-lane write data and mask, waits for completion (with an optional
// timeout) and returns extended load data.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned h/hu (off=3) and w
// (off!=0) requests get an error response instead of being truncated to alignment.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255, // max WAIT cycles before error; 0 = wait forever
  parameter int unsigned CNT_W   = 8    // timeout counter width, must hold TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Request decode: legality, effective offset, lane-shifted store data and mask.
  logic        op_illegal;
  logic        req_fault;
  logic [1:0]  eff_off;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic [31:0] st_data;
  logic [3:0]  st_mask;

  // Decode the incoming request as seen in IDLE.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    op_illegal = (req_op == 3'b011) || (req_op[2:1] == 2'b11) || (req_wr && req_op[2]);
    eff_off    = req_addr[1:0];
    // Truncate to natural alignment; in the trap build these cases fault instead.
    if (req_op[1:0] == 2'b01 && req_addr[1:0] == 2'b11) eff_off = 2'b10;
    if (req_op[1:0] == 2'b10) eff_off = 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
    req_fault = op_illegal
              || ((req_op[1:0] == 2'b01) && (req_addr[1:0] == 2'b11))
              || ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_fault = op_illegal;
`endif
    case (req_op[1:0])
      2'b00: begin
        lane_mask = 4'b0001;
        lane_data = {24'd0, req_wdata[7:0]};
      end
      2'b01: begin
        lane_mask = 4'b0011;
        lane_data = {16'd0, req_wdata[15:0]};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = req_wdata;
      end
    endcase
    st_data = lane_data << {eff_off, 3'b000};
    st_mask = lane_mask << eff_off;
    if (!req_wr) begin
      st_data = 32'd0;
      st_mask = 4'd0;
    end
  end

  // Load-data extraction from the returned word using the latched op and offset.
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  // Select the byte/halfword lane and sign- or zero-extend it.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (op_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // Next-state and datapath update for the IDLE/REQ/WAIT/RESP sequencer.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          off_d   = eff_off;
          wr_d    = req_wr;
          addr_d  = {req_addr[31:2], 2'b00};
          wdata_d = st_data;
          wmask_d = st_mask;
          rdata_d = 32'd0;
          err_d   = req_fault;
          state_d = req_fault ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          // Data arriving on the timeout cycle still wins.
          rdata_d = wr_q ? 32'd0 : ld_ext;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      off_q   <= 2'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_valid  = (state_q == S_REQ);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_wr     = wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = {4'd0, wmask_q};

endmodule
